// File: rtl/typed_ndata_unpack_if.sv
// Shared types and stream interfaces for the typed ndata unpacker:
// the byte-lane typed input stream and the 64-bit element-lane output stream.
package typed_ndata_pkg;

    typedef logic [63:0] data64_t;

    typedef enum logic [2:0] {
        TYPE_U8,
        TYPE_U16,
        TYPE_U32,
        TYPE_I32,
        TYPE_F32,
        TYPE_U64,
        TYPE_I64,
        TYPE_F64
    } type_t;

    function automatic int unsigned GET_TYPE_WIDTH(type_t t);
        case (t)
            TYPE_U8:                      return 8;
            TYPE_U16:                     return 16;
            TYPE_U32, TYPE_I32, TYPE_F32: return 32;
            default:                      return 64;
        endcase
    endfunction

endpackage

interface typed_ndata_i #(
    parameter int unsigned DATABEAT_SIZE = 64
);
    logic [DATABEAT_SIZE-1:0][7:0] data;
    logic [DATABEAT_SIZE-1:0]      keep;
    logic                          last;
    logic                          valid;
    logic                          ready;
    typed_ndata_pkg::type_t        typ;

    modport m (output data, keep, last, valid, typ, input ready);
    modport s (input data, keep, last, valid, typ, output ready);
endinterface

interface ndata_i #(
    parameter type         T            = typed_ndata_pkg::data64_t,
    parameter int unsigned NUM_ELEMENTS = 8
);
    T [NUM_ELEMENTS-1:0]    data;
    logic [NUM_ELEMENTS-1:0] keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/typed_ndata_unpack.sv
// Regroups typed byte beats into 64-bit element lanes (32-bit types zero-extended, two beats out).
// Optional TYPED_UNPACK_STATS_EN adds packet / element counters.
module typed_ndata_unpack
    import typed_ndata_pkg::*;
#(
    parameter int unsigned NUM_ELEMENTS  = 8,
    parameter int unsigned DATABEAT_SIZE = 8 * NUM_ELEMENTS
) (
    input  logic        clk,
    input  logic        rst_n,
    typed_ndata_i.s     in,
    ndata_i.m           out
`ifdef TYPED_UNPACK_STATS_EN
    ,
    output logic [31:0] pkt_count,
    output logic [31:0] elem_count
`endif
);

    localparam int unsigned NE   = NUM_ELEMENTS;
    localparam int unsigned HALF = DATABEAT_SIZE / 2;

    if (DATABEAT_SIZE != 8 * NUM_ELEMENTS) begin : g_bad_size
        $fatal(1, "typed_ndata_unpack: DATABEAT_SIZE %0d != 8*NUM_ELEMENTS %0d",
               DATABEAT_SIZE, 8 * NUM_ELEMENTS);
    end

    typedef enum logic {
        PH_LOWER,
        PH_UPPER
    } phase_t;

    phase_t               phase_q, phase_d;
    logic                 out_valid_q, out_valid_d;
    data64_t [NE-1:0]     out_data_q, out_data_d;
    logic    [NE-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;

    data64_t [NE-1:0]     lane_wide, lane_lo, lane_hi;
    logic    [NE-1:0]     keep_wide, keep_lo, keep_hi;

    int unsigned          width;
    logic                 wide;
    logic                 upper_empty;
    logic                 load;
    logic                 split;

    // Fixed lane extraction for each of the three byte groupings
    for (genvar i = 0; i < NE; i++) begin : g_lane
        assign lane_wide[i] = in.data[8*i +: 8];
        assign lane_lo[i]   = {32'h0, in.data[4*i +: 4]};
        assign lane_hi[i]   = {32'h0, in.data[HALF + 4*i +: 4]};
        assign keep_wide[i] = in.keep[8*i];
        assign keep_lo[i]   = in.keep[4*i];
        assign keep_hi[i]   = in.keep[HALF + 4*i];
    end

    // Load decision, lane select and phase/valid next state
    always_comb begin
        width       = GET_TYPE_WIDTH(in.typ);
        wide        = (width == 32'd64);
        upper_empty = ~|in.keep[DATABEAT_SIZE-1:HALF];
        load        = in.valid && (!out_valid_q || out.ready);
        // Lower half of a 32-bit beat whose upper half still carries data: hold the beat
        split       = !wide && (phase_q == PH_LOWER) && !upper_empty;

        out_data_d  = lane_lo;
        out_keep_d  = keep_lo;
        out_last_d  = in.last;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;

        if (wide) begin
            out_data_d = lane_wide;
            out_keep_d = keep_wide;
        end else if (phase_q == PH_UPPER) begin
            out_data_d = lane_hi;
            out_keep_d = keep_hi;
        end

        if (split) begin
            out_last_d = 1'b0;
        end

        if (load) begin
            out_valid_d = 1'b1;
            phase_d     = split ? PH_UPPER : PH_LOWER;
        end else if (out.ready) begin
            out_valid_d = 1'b0;
        end

        in.ready = rst_n && load && !split;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            phase_q     <= PH_LOWER;
        end else begin
            out_valid_q <= out_valid_d;
            phase_q     <= phase_d;
            if (load) begin
                out_data_q <= out_data_d;
                out_keep_q <= out_keep_d;
                out_last_q <= out_last_d;
            end
        end
    end

    assign out.valid = out_valid_q;
    assign out.data  = out_data_q;
    assign out.keep  = out_keep_q;
    assign out.last  = out_last_q;

`ifdef TYPED_UNPACK_STATS_EN
    // Counters advance on output handshakes and wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count  <= 32'd0;
            elem_count <= 32'd0;
        end else if (out_valid_q && out.ready) begin
            pkt_count  <= pkt_count + 32'(out_last_q);
            elem_count <= elem_count + 32'($countones(out_keep_q));
        end
    end
`endif

    a_width_legal: assert property (@(posedge clk) disable iff (!rst_n)
        in.valid |-> (width == 32'd32 || width == 32'd64))
        else $fatal(1, "typed_ndata_unpack: unsupported type width %0d", width);

endmodule

// File: tb/tb_typed_ndata_unpack.sv
// Self-checking bench for typed_ndata_unpack: directed scenarios plus randomized packets
// checked against a queue-based element model.
`timescale 1ns/1ps
module tb_typed_ndata_unpack;
    import typed_ndata_pkg::*;

    localparam int unsigned NE = 8;
    localparam int unsigned DB = 64;

    typedef struct packed {
        logic [NE-1:0][63:0] data;
        logic [NE-1:0]       keep;
        logic                last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typed_ndata_i #(.DATABEAT_SIZE(DB)) in_if ();
    ndata_i #(.T(data64_t), .NUM_ELEMENTS(NE)) out_if ();

`ifdef TYPED_UNPACK_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] elem_count;
`endif

    typed_ndata_unpack #(.NUM_ELEMENTS(NE), .DATABEAT_SIZE(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_if),
        .out   (out_if)
`ifdef TYPED_UNPACK_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .elem_count (elem_count)
`endif
    );

    int    checks = 0;
    int    failures = 0;
    int    hs_count = 0;
    int    rdy_mode = 0;   // 0 always ready, 1 alternate, 2 random, 3 held low
    beat_t exp_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: elements of size esz laid out little-endian; NE elements per output beat;
    // a 32-bit beat produces its second output beat only if any upper-half byte is kept.
    function automatic void model_push(input logic [DB-1:0][7:0] b, input logic [DB-1:0] k,
                                       input logic last, input type_t t);
        int unsigned esz = GET_TYPE_WIDTH(t) / 8;
        int unsigned nbeats = 1;
        beat_t bt;
        if (esz == 4) begin
            for (int x = DB/2; x < DB; x++) if (k[x]) nbeats = 2;
        end
        for (int j = 0; j < int'(nbeats); j++) begin
            bt = '0;
            for (int i = 0; i < NE; i++) begin
                int e = j * NE + i;
                for (int x = 0; x < int'(esz); x++) bt.data[i][8*x +: 8] = b[e*int'(esz) + x];
                bt.keep[i] = k[e*int'(esz)];
            end
            bt.last = last && (j == int'(nbeats) - 1);
            exp_q.push_back(bt);
        end
    endfunction

    function automatic logic [DB-1:0][7:0] seq_bytes(input int start);
        logic [DB-1:0][7:0] b;
        for (int i = 0; i < DB; i++) b[i] = 8'(start + i);
        return b;
    endfunction

    function automatic logic [DB-1:0][7:0] rand_bytes();
        logic [DB-1:0][7:0] b;
        for (int i = 0; i < DB; i++) b[i] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // Output ready generator
    initial begin
        logic alt = 1'b0;
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_if.ready = 1'b1;
                1: begin alt = ~alt; out_if.ready = alt; end
                2: out_if.ready = 1'($urandom_range(0, 1));
                default: out_if.ready = 1'b0;
            endcase
        end
    end

    // Compare process: stall stability and in-order beat checking against the model
    initial begin
        logic  p_valid = 1'b0;
        logic  p_ready = 1'b0;
        beat_t p_beat;
        beat_t cur;
        beat_t e;
        forever begin
            @(negedge clk);
            cur = {out_if.data, out_if.keep, out_if.last};
            if (!rst_n) begin
                p_valid = 1'b0;
            end else begin
                if (p_valid && !p_ready) begin
                    chk("stall_valid", 64'(out_if.valid), 64'd1);
                    chk("stall_hold_changed", 64'(cur != p_beat), 64'd0);
                end
                if (out_if.valid && out_if.ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat_lane0", cur.data[0], 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < NE; i++)
                            chk($sformatf("beat%0d_lane%0d_data", hs_count, i), cur.data[i], e.data[i]);
                        chk($sformatf("beat%0d_keep", hs_count), 64'(cur.keep), 64'(e.keep));
                        chk($sformatf("beat%0d_last", hs_count), 64'(cur.last), 64'(e.last));
                    end
                    hs_count++;
                end
                p_valid = out_if.valid;
                p_ready = out_if.ready;
                p_beat  = cur;
            end
        end
    end

    task automatic drive(input logic [DB-1:0][7:0] b, input logic [DB-1:0] k, input logic last,
                         input type_t t, output logic first_rdy, output int ncyc);
        logic r;
        in_if.data  = b;
        in_if.keep  = k;
        in_if.last  = last;
        in_if.typ   = t;
        in_if.valid = 1'b1;
        ncyc = 0;
        first_rdy = 1'b0;
        forever begin
            @(negedge clk);
            r = in_if.ready;
            if (ncyc == 0) first_rdy = r;
            ncyc++;
            @(posedge clk);
            #1;
            if (r) break;
            if (ncyc >= 200) begin
                chk("in_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DB-1:0][7:0] b;
        logic [DB-1:0]      k;
        logic               fr;
        int                 nc;
        int                 hs0;
        type_t              tsel[6] = '{TYPE_U32, TYPE_I32, TYPE_F32, TYPE_U64, TYPE_I64, TYPE_F64};

        in_if.valid = 1'b1;
        in_if.data  = '0;
        in_if.keep  = '1;
        in_if.last  = 1'b1;
        in_if.typ   = TYPE_U32;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_if.valid), 64'd0);
        chk("reset_in_ready", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: 64-bit, two beats
        b = seq_bytes(0);
        model_push(b, '1, 1'b0, TYPE_U64);
        chk("model_s1_b0_lane0", exp_q[$].data[0], 64'h0706050403020100);
        chk("model_s1_b0_keep", 64'(exp_q[$].keep), 64'hFF);
        drive(b, '1, 1'b0, TYPE_U64, fr, nc);
        chk("s1_b0_in_ready", 64'(fr), 64'd1);
        b = seq_bytes(64);
        model_push(b, '1, 1'b1, TYPE_U64);
        chk("model_s1_b1_lane7", exp_q[$].data[7], 64'h7F7E7D7C7B7A7978);
        drive(b, '1, 1'b1, TYPE_U64, fr, nc);
        chk("s1_b1_in_ready", 64'(fr), 64'd1);
        drain();

        // Scenario 3: 32-bit short last beat, lower half only
        b = rand_bytes();
        k = '0;
        k[19:0] = '1;
        model_push(b, k, 1'b1, TYPE_U32);
        chk("model_s3_keep", 64'(exp_q[$].keep), 64'h1F);
        chk("model_s3_last", 64'(exp_q[$].last), 64'd1);
        drive(b, k, 1'b1, TYPE_U32, fr, nc);
        chk("s3_in_ready", 64'(fr), 64'd1);
        drain();

`ifdef TYPED_UNPACK_STATS_EN
        chk("stats_pkt_count", 64'(pkt_count), 64'd2);
        chk("stats_elem_count", 64'(elem_count), 64'd21);
`endif

        // Scenario 2: 32-bit full last beat -> two output beats
        b = seq_bytes(0);
        model_push(b, '1, 1'b1, TYPE_I32);
        chk("model_s2_b0_lane0", exp_q[$-1].data[0], 64'h0000000003020100);
        chk("model_s2_b1_lane0", exp_q[$].data[0], 64'h0000000023222120);
        chk("model_s2_b1_lane7", exp_q[$].data[7], 64'h000000003F3E3D3C);
        drive(b, '1, 1'b1, TYPE_I32, fr, nc);
        chk("s2_first_in_ready", 64'(fr), 64'd0);
        chk("s2_accept_cycles", 64'(nc), 64'd2);
        drain();

        // Scenario 4: 3-beat 32-bit packet under alternating out.ready
        rdy_mode = 1;
        hs0 = hs_count;
        for (int j = 0; j < 3; j++) begin
            b = rand_bytes();
            model_push(b, '1, 1'(j == 2), TYPE_F32);
            drive(b, '1, 1'(j == 2), TYPE_F32, fr, nc);
        end
        drain();
        chk("s4_out_beats", 64'(hs_count - hs0), 64'd6);
        rdy_mode = 0;

        // Scenario 5: reset while in UPPER with a held output beat
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        in_if.data  = rand_bytes();
        in_if.keep  = '1;
        in_if.last  = 1'b1;
        in_if.typ   = TYPE_U32;
        in_if.valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s5_pre_out_valid", 64'(out_if.valid), 64'd1);
        chk("s5_pre_in_ready", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_if.valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5_post_out_valid", 64'(out_if.valid), 64'd0);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        b = seq_bytes(8'h80);
        model_push(b, '1, 1'b1, TYPE_U32);
        drive(b, '1, 1'b1, TYPE_U32, fr, nc);
        drain();

        // Randomized packets with random output backpressure
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            type_t       t = tsel[$urandom_range(0, 5)];
            int unsigned esz = GET_TYPE_WIDTH(t) / 8;
            int          len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                b = rand_bytes();
                k = '1;
                if (j == len - 1) begin
                    int nel = int'($urandom_range(0, DB / esz));
                    k = '0;
                    for (int x = 0; x < nel * int'(esz); x++) k[x] = 1'b1;
                end
                model_push(b, k, 1'(j == len - 1), t);
                drive(b, k, 1'(j == len - 1), t, fr, nc);
            end
        end
        drain();
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/typed_ndata_unpack.md
Name: typed_ndata_unpack

Overview:
- Downstream consumer of the byte-level typed ndata stream produced by AXI-to-typed-ndata conversion.
- Regroups DATABEAT_SIZE bytes per beat into NUM_ELEMENTS 64-bit element lanes, as selected by the packet type width (32 or 64 bit).
- 32-bit elements are zero-extended into 64-bit lanes; one input beat yields one or two output beats.
- Output is a registered ndata stream feeding element-wise operators.

Parameters:
- NUM_ELEMENTS, 8, number of 64-bit output lanes.
- DATABEAT_SIZE, 8 * NUM_ELEMENTS, bytes per input beat; must equal 8 * NUM_ELEMENTS (elaboration-time $fatal otherwise).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in  typed_ndata_i.s  #(DATABEAT_SIZE)  byte lanes data[i], per-byte keep[i], last, valid, ready, typ (type_t).
- out  ndata_i.m  #(data64_t, NUM_ELEMENTS)  element lanes data[i], per-element keep[i], last, valid, ready.
- pkt_count  output  32  packets emitted (only with TYPED_UNPACK_STATS_EN).
- elem_count  output  32  elements emitted, i.e. popcount of out.keep (only with TYPED_UNPACK_STATS_EN).

Behaviour:
- Reset values: out.valid=0, phase=LOWER, in.ready=0 while rst_n=0; out.data/keep/last are don't-care.
- Reset mid-packet: the held output beat and the current phase are discarded; the next accepted beat starts in LOWER.
- Width select: w = GET_TYPE_WIDTH(in.typ).
  - Concurrent assertion: when in.valid, w is 32 or 64; otherwise $fatal with the width value.
  - typ is constant within a packet (upstream contract); it is not checked.
- Output register, single stage:
  - load = in.valid && (!out.valid || out.ready).
  - On load, out.valid<=1. Else if out.ready, out.valid<=0.
  - Latency from input beat presentation to out.valid is 1 cycle; full throughput in 64-bit mode.
  - out.data/keep/last hold stable while out.valid && !out.ready.
- 64-bit mode:
  - out.data[i] = {in.data[8i+7], ..., in.data[8i]} (little-endian).
  - out.keep[i] = in.keep[8i]; out.last = in.last.
  - in.ready = load (i.e. in.valid && output register free).
- 32-bit mode: phase FSM with states LOWER and UPPER.
  - Define upper_empty = ~|in.keep[DATABEAT_SIZE-1 : DATABEAT_SIZE/2].
  - LOWER:
    - out.data[i] = {32'h0, in.data[4i+3..4i]}.
    - out.keep[i] = in.keep[4i].
    - If upper_empty: in.ready=load, out.last=in.last, phase stays LOWER.
    - Else: in.ready=0 (beat held), out.last=0, phase->UPPER on load.
  - UPPER:
    - Lanes taken from bytes DATABEAT_SIZE/2 + 4i.., zero-extended.
    - out.keep[i] = in.keep[DATABEAT_SIZE/2 + 4i].
    - in.ready=load, out.last=in.last, phase->LOWER on load.
- Phase changes only on load; out.ready stalls freeze the FSM.
- A last beat with all keep zero is emitted as one beat with keep=0 and last=1.
- Non-last beats are full (upstream contract); no special handling.

Optional Feature:
- TYPED_UNPACK_STATS_EN defined:
  - pkt_count increments on each out handshake with out.last.
  - elem_count adds popcount(out.keep) on each out handshake.
  - Both counters reset to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent; no other behaviour changes.

Test Plan (NUM_ELEMENTS=8, DATABEAT_SIZE=64, out.ready=1 unless stated):
1. 64-bit type, 2-beat packet, bytes 0x00..0x7F, keep all ones -> 2 beats; beat0 data[0]=0x0706050403020100, keep=0xFF, last=0; beat1 data[7]=0x7F7E7D7C7B7A7978, last=1; in.ready high both cycles.
2. 32-bit type, single full last beat, bytes 0x00..0x3F -> 2 beats; beat0 data[0]=0x0000000003020100, last=0; beat1 data[0]=0x0000000023222120, data[7]=0x3F3E3D3C, last=1; in.ready=0 on the first load, 1 on the second.
3. 32-bit type, last beat with keep[19:0] set only -> one beat, keep=0x1F, last=1; in.ready high on that load; phase stays LOWER.
4. 32-bit type, 3-beat packet, out.ready pattern 1,0,1,0,... -> 6 output beats in order, no duplicates or drops; data stable during every stall; last only on the 6th.
5. rst_n low for 1 cycle while phase=UPPER with out.valid=1 -> out.valid=0 next cycle; next 32-bit beat emits its lower half first.
6. With TYPED_UNPACK_STATS_EN: scenarios 1 then 3 -> pkt_count=2, elem_count=21.
